// File: rtl/rom_data_arbiter.sv
// rom_data_arbiter: shares one synchronous ROM data port between two
// level-request read clients using round-robin arbitration.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   r0_start/r0_addr      requester 0 (CPU data bus) request level + word address
//   r0_done/r0_q          requester 0 one-cycle completion pulse + held read data
//   r1_start/r1_addr      requester 1 (debug/loader) request level + word address
//   r1_done/r1_q          requester 1 one-cycle completion pulse + held read data
//   rom_addr/rom_q        ROM data port (rom_q valid one edge after rom_addr sampled)
//   busy                  high whenever a transaction is in flight
module rom_data_arbiter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        r0_start,
  input  logic [8:0]  r0_addr,
  output logic        r0_done,
  output logic [31:0] r0_q,
  input  logic        r1_start,
  input  logic [8:0]  r1_addr,
  output logic        r1_done,
  output logic [31:0] r1_q,
  output logic [8:0]  rom_addr,
  input  logic [31:0] rom_q,
  output logic        busy
);

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_READ    = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic           r_winner;
  logic           r_last;
  logic           w_elig0;
  logic           w_elig1;
  logic           w_req_any;
  logic           w_grant_id;
  logic           w_winner_nxt;
  logic           w_last_nxt;
  logic [AW-1:0]  w_rom_addr_nxt;
  logic [DW-1:0]  w_r0_q_nxt;
  logic [DW-1:0]  w_r1_q_nxt;
  logic           w_r0_done_nxt;
  logic           w_r1_done_nxt;

  // A start still held during its own done cycle must not be re-accepted.
  assign w_elig0   = r0_start & ~r0_done;
  assign w_elig1   = r1_start & ~r1_done;
  assign w_req_any = w_elig0 | w_elig1;
  // Contention goes to whoever was not served last; otherwise the lone requester.
  assign w_grant_id = (w_elig0 & w_elig1) ? ~r_last : w_elig1;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_req_any) w_state_nxt = S_READ;
      S_READ:    w_state_nxt = S_CAPTURE;
      S_CAPTURE: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    w_rom_addr_nxt = rom_addr;
    w_winner_nxt   = r_winner;
    w_last_nxt     = r_last;
    w_r0_q_nxt     = r0_q;
    w_r1_q_nxt     = r1_q;
    w_r0_done_nxt  = 1'b0;
    w_r1_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req_any) begin
          w_rom_addr_nxt = w_grant_id ? r1_addr : r0_addr;
          w_winner_nxt   = w_grant_id;
          w_last_nxt     = w_grant_id;
        end
      end
      S_CAPTURE: begin
        if (r_winner) begin
          w_r1_q_nxt    = rom_q;
          w_r1_done_nxt = 1'b1;
        end else begin
          w_r0_q_nxt    = rom_q;
          w_r0_done_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs and arbitration history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_addr <= AW'(0);
      r0_q     <= DW'(0);
      r1_q     <= DW'(0);
      r0_done  <= 1'b0;
      r1_done  <= 1'b0;
      busy     <= 1'b0;
      r_winner <= 1'b0;
      r_last   <= 1'b1;
    end else begin
      rom_addr <= w_rom_addr_nxt;
      r0_q     <= w_r0_q_nxt;
      r1_q     <= w_r1_q_nxt;
      r0_done  <= w_r0_done_nxt;
      r1_done  <= w_r1_done_nxt;
      busy     <= (w_state_nxt != S_IDLE);
      r_winner <= w_winner_nxt;
      r_last   <= w_last_nxt;
    end
  end

endmodule

// File: tb/tb_rom_data_arbiter.sv
// Bench for rom_data_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model.
module tb_rom_data_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        r0_start, r1_start;
  logic [8:0]  r0_addr, r1_addr;
  logic        r0_done, r1_done;
  logic [31:0] r0_q, r1_q;
  logic [8:0]  rom_addr;
  logic [31:0] rom_q;
  logic        busy;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [512];

  // Reference model state: one transaction in flight at most.
  int          m_cyc;
  int          m_owner;
  int          m_acc;
  int          m_last;
  logic [8:0]  m_addr;
  logic [8:0]  m_rom_addr;
  logic [31:0] m_q [2];
  logic        m_done [2];

  rom_data_arbiter dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .r0_start (r0_start),
    .r0_addr  (r0_addr),
    .r0_done  (r0_done),
    .r0_q     (r0_q),
    .r1_start (r1_start),
    .r1_addr  (r1_addr),
    .r1_done  (r1_done),
    .r1_q     (r1_q),
    .rom_addr (rom_addr),
    .rom_q    (rom_q),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data for the address sampled at an edge appears after it.
  always @(posedge clk) rom_q <= mem[rom_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner    = -1;
    m_acc      = 0;
    m_last     = 1;
    m_addr     = '0;
    m_rom_addr = '0;
    m_q[0]     = '0;
    m_q[1]     = '0;
    m_done[0]  = 1'b0;
    m_done[1]  = 1'b0;
  endtask

  // One rising edge of the reference: a read accepted at edge k completes at k+2.
  task automatic model_edge();
    logic nd0, nd1, e0, e1;
    int w;
    nd0 = 1'b0;
    nd1 = 1'b0;
    m_cyc++;
    if (m_owner >= 0) begin
      if (m_cyc - m_acc == 2) begin
        m_q[m_owner] = mem[m_addr];
        if (m_owner == 0) nd0 = 1'b1; else nd1 = 1'b1;
        m_owner = -1;
      end
    end else begin
      e0 = r0_start && !m_done[0];
      e1 = r1_start && !m_done[1];
      if (e0 || e1) begin
        if (e0 && e1) w = 1 - m_last;
        else          w = e0 ? 0 : 1;
        m_owner    = w;
        m_acc      = m_cyc;
        m_last     = w;
        m_addr     = (w == 1) ? r1_addr : r0_addr;
        m_rom_addr = m_addr;
      end
    end
    m_done[0] = nd0;
    m_done[1] = nd1;
  endtask

  task automatic compare_all(input string where);
    chk({where, ":r0_done"},  32'(r0_done),  32'(m_done[0]));
    chk({where, ":r1_done"},  32'(r1_done),  32'(m_done[1]));
    chk({where, ":r0_q"},     r0_q,          m_q[0]);
    chk({where, ":r1_q"},     r1_q,          m_q[1]);
    chk({where, ":rom_addr"}, 32'(rom_addr), 32'(m_rom_addr));
    chk({where, ":busy"},     32'(busy),     32'(m_owner >= 0));
    chk({where, ":done_excl"}, 32'(r0_done & r1_done), 32'd0);
  endtask

  // Advance one clock; outputs sampled 1ns after the edge, inputs then free to change.
  task automatic tick(input string where);
    @(posedge clk);
    #1;
    if (reset_n) model_edge();
    compare_all(where);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int prev;
    int seen;

    for (int i = 0; i < 512; i++) mem[i] = $urandom;
    mem[1] = 32'h1111_1111;
    mem[2] = 32'h2222_2222;
    mem[3] = 32'h3333_3333;
    mem[5] = 32'hDEAD_BEEF;
    mem[7] = 32'h7777_7777;

    r0_start = 1'b0; r1_start = 1'b0;
    r0_addr  = '0;   r1_addr  = '0;
    reset_n  = 1'b0;
    m_cyc    = 0;
    model_reset();
    #3;
    compare_all("reset");
    repeat (2) tick("reset_hold");
    reset_n = 1'b1;

    // Simultaneous requests right after reset: r0 wins, r1 follows.
    r0_start = 1'b1; r0_addr = 9'd1;
    r1_start = 1'b1; r1_addr = 9'd2;
    tick("sim_k");
    chk("sim_rom_addr_k", 32'(rom_addr), 32'd1);
    tick("sim_k1");
    tick("sim_k2");
    chk("sim_r0_done", 32'(r0_done), 32'd1);
    chk("sim_r0_q", r0_q, 32'h1111_1111);
    r0_start = 1'b0;
    tick("sim_k3");
    chk("sim_r1_accept_addr", 32'(rom_addr), 32'd2);
    tick("sim_k4");
    tick("sim_k5");
    chk("sim_r1_done", 32'(r1_done), 32'd1);
    chk("sim_r1_q", r1_q, 32'h2222_2222);
    r1_start = 1'b0;
    tick("sim_idle");

    // Single read of word 5.
    r0_start = 1'b1; r0_addr = 9'd5;
    tick("single_k");
    chk("single_rom_addr", 32'(rom_addr), 32'd5);
    tick("single_k1");
    tick("single_k2");
    chk("single_done", 32'(r0_done), 32'd1);
    chk("single_q", r0_q, 32'hDEAD_BEEF);
    chk("single_r1_q_kept", r1_q, 32'h2222_2222);
    chk("single_r1_done", 32'(r1_done), 32'd0);
    r0_start = 1'b0;
    tick("single_tail");

    // Address change while the read is in flight has no effect.
    r0_start = 1'b1; r0_addr = 9'd3;
    tick("midop_k");
    r0_addr = 9'd7;
    tick("midop_k1");
    tick("midop_k2");
    chk("midop_q", r0_q, 32'h3333_3333);
    r0_start = 1'b0;
    tick("midop_tail");

    // Start held through its own done cycle yields exactly one completion.
    r1_start = 1'b1; r1_addr = 9'd4;
    n = 0;
    for (int i = 0; i < 10 && n == 0; i++) begin
      tick("held_wait");
      if (r1_done) n++;
    end
    if (n == 0) chk("held_timeout", 32'd0, 32'd1);
    tick("held_done_cycle");
    r1_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick("held_after");
      if (r1_done) n++;
    end
    chk("held_single_pulse", 32'(n), 32'd1);

    // Both held continuously: completions must alternate between requesters.
    r0_start = 1'b1; r0_addr = 9'd10;
    r1_start = 1'b1; r1_addr = 9'd11;
    prev = -1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick("fair");
      if (r0_done || r1_done) begin
        if (prev >= 0) chk("fair_alternate", 32'(r1_done ? 1 : 0), 32'(1 - prev));
        prev = r1_done ? 1 : 0;
        seen++;
      end
    end
    chk("fair_count", 32'(seen), 32'd4);
    r0_start = 1'b0; r1_start = 1'b0;
    repeat (4) tick("fair_drain");

    // Reset during READ discards the read.
    r0_start = 1'b1; r0_addr = 9'd9;
    tick("rst_accept");
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    compare_all("rst_async");
    r0_start = 1'b0;
    repeat (2) tick("rst_hold");
    reset_n = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick("rst_release");
      if (r0_done || r1_done) n++;
    end
    chk("rst_no_done", 32'(n), 32'd0);

    // Random traffic: level requests, random drops/re-raises, address churn.
    for (int i = 0; i < 600; i++) begin
      if (!r0_start) begin
        if ($urandom_range(0, 3) == 0) begin r0_start = 1'b1; r0_addr = 9'($urandom); end
      end else if (r0_done) begin
        if ($urandom_range(0, 1) == 0) r0_start = 1'b0;
      end
      if (!r1_start) begin
        if ($urandom_range(0, 3) == 0) begin r1_start = 1'b1; r1_addr = 9'($urandom); end
      end else if (r1_done) begin
        if ($urandom_range(0, 1) == 0) r1_start = 1'b0;
      end
      if ($urandom_range(0, 15) == 0) r0_addr = 9'($urandom);
      if ($urandom_range(0, 15) == 0) r1_addr = 9'($urandom);
      if ($urandom_range(0, 63) == 0) r0_start = 1'b0;
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rom_data_arbiter.md
ROM_DATA_ARBITER -- requirements
Module: rom_data_arbiter

Interface
REQ-001 Parameters: none; address width fixed at 9 bits (512 words), data width fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 r0_start  input  1  requester 0 (CPU data bus) read request, level, held until r0_done.
REQ-005 r0_addr  input  9  requester 0 word address.
REQ-006 r0_done  output  1  one-cycle pulse: r0_q valid.
REQ-007 r0_q  output  32  requester 0 read data, registered, held until next r0 completion.
REQ-008 r1_start  input  1  requester 1 (debug/loader) read request, level, held until r1_done.
REQ-009 r1_addr  input  9  requester 1 word address.
REQ-010 r1_done  output  1  one-cycle pulse: r1_q valid.
REQ-011 r1_q  output  32  requester 1 read data, registered, held until next r1 completion.
REQ-012 rom_addr  output  9  to ROM data-port address; registered.
REQ-013 rom_q  input  32  from ROM data-port output; valid one clock edge after rom_addr sampled.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 FSM states: IDLE, READ, CAPTURE; encoding implementer's choice.
REQ-016 IDLE: on edge with any eligible request -> latch winner's address into rom_addr, record winner id, go READ; else stay IDLE, rom_addr unchanged.
REQ-017 Eligibility: rN_start high AND rN_done low on that edge (suppresses re-acceptance of a start still held during its own done cycle).
REQ-018 READ: unconditional -> CAPTURE (ROM samples rom_addr on this edge).
REQ-019 CAPTURE: register rom_q into winner's q, set winner's done high for exactly one cycle, -> IDLE; other requester's q and done untouched.
REQ-020 Latency: start accepted at edge k -> done high and q valid in cycle following edge k+2; one read per 3 cycles max.
REQ-021 Arbitration round-robin: single request -> grant it; both eligible -> grant requester not served last; last_served updates on each grant.
REQ-022 After reset last_served = 1, so first simultaneous request grants requester 0.
REQ-023 Address/start changes after acceptance have no effect on in-flight read; start dropped mid-transaction still yields done and q.
REQ-024 Non-winning request stays pending; accepted at earliest next IDLE edge where eligible; max wait for any requester = one transaction (3 cycles) when other also requests.
REQ-025 r0_done and r1_done never high in same cycle.
REQ-026 No new request accepted outside IDLE; starts seen in READ/CAPTURE are evaluated only at next IDLE edge.

Reset
REQ-027 reset_n low asynchronously forces: state IDLE, rom_addr 0, r0_q 0, r1_q 0, r0_done 0, r1_done 0, busy 0, last_served 1.
REQ-028 Reset during READ or CAPTURE discards in-flight read; no done pulse emitted for it after release.
REQ-029 First acceptance possible on first rising edge with reset_n high.

Verification
REQ-030 Single read: ROM word 5 = 0xDEADBEEF, r0_start=1, r0_addr=5 at edge k -> rom_addr=5 after k, r0_done=1 and r0_q=0xDEADBEEF in cycle after k+2, r1 outputs unchanged.
REQ-031 Simultaneous after reset: r0_addr=1 (0x11111111), r1_addr=2 (0x22222222), both start at edge k -> r0_done after k+2, r1 accepted k+3, r1_done after k+5 with 0x22222222.
REQ-032 Fairness: both starts held continuously for 12 cycles, each re-raised after done -> dones alternate r0,r1,r0,r1; no requester gets two consecutive grants.
REQ-033 Held start: r1_start held high through its done cycle then dropped -> exactly one r1_done pulse, no second read.
REQ-034 Mid-op change: r0_addr changed 3->7 in READ -> r0_q = word 3.
REQ-035 Reset mid-op: reset_n low in READ -> all outputs 0 immediately; after release no done pulse until new start.
